// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execution unit. Single-cycle integer ops plus
// iterative shift-add multiply and restoring unsigned divide/remainder.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_ctrl,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             illegal_op
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] hi_reg;      // multiply: upper product half; divide: partial remainder
    logic [WIDTH-1:0] lo_reg;      // multiply: multiplier/lower half; divide: dividend/quotient
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             illegal_reg;

    logic             accept;
    logic             is_iter_in;
    logic             is_illegal_in;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_tmp;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;
    logic [WIDTH-1:0] final_res;

    assign accept        = (state_reg == IDLE) && in_valid && !flush;
    assign is_iter_in    = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_MULHU) ||
                           (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);
    assign is_illegal_in = (alu_ctrl[3:1] == 3'b111);
    assign shamt         = in2[SHW-1:0];

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign alu_result = result_reg;
    assign zero_flag  = zero_reg;
    assign illegal_op = illegal_reg;

    // Single-cycle function set, evaluated on the live operands at acceptance.
    always_comb begin
        single_res = '0;
        case (alu_ctrl)
            OP_AND:  single_res = in1 & in2;
            OP_OR:   single_res = in1 | in2;
            OP_ADD:  single_res = in1 + in2;
            OP_SLL:  single_res = in1 << shamt;
            OP_SUB:  single_res = in1 - in2;
            OP_SRL:  single_res = in1 >> shamt;
            OP_XOR:  single_res = in1 ^ in2;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SRA:  single_res = $signed(in1) >>> shamt;
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            default: single_res = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide, plus the result
    // selected from the post-iteration registers on the final step.
    always_comb begin
        mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
        div_tmp  = {hi_reg, lo_reg[WIDTH-1]};
        div_diff = div_tmp - {1'b0, b_reg};
        div_ge   = (div_tmp >= {1'b0, b_reg});
        if (op_reg == OP_MUL || op_reg == OP_MULHU) begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else begin
            // A zero divisor always "fits", giving all-ones quotient and the
            // dividend as remainder without any special casing.
            hi_step = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];
            lo_step = {lo_reg[WIDTH-2:0], div_ge};
        end
        case (op_reg)
            OP_MUL:   final_res = lo_step;
            OP_MULHU: final_res = hi_step;
            OP_DIVU:  final_res = lo_step;
            default:  final_res = hi_step;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = is_iter_in ? BUSY : DONE;
            BUSY: if (cnt_reg == CW'(1)) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            op_reg      <= '0;
            b_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                op_reg <= alu_ctrl;
                b_reg  <= in2;
                hi_reg <= '0;
                lo_reg <= in1;
                if (is_iter_in) begin
                    cnt_reg <= CW'(WIDTH);
                end else begin
                    result_reg  <= is_illegal_in ? '0 : single_res;
                    zero_reg    <= is_illegal_in || (single_res == '0);
                    illegal_reg <= is_illegal_in;
                end
            end else if (state_reg == BUSY) begin
                hi_reg  <= hi_step;
                lo_reg  <= lo_step;
                cnt_reg <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    result_reg  <= final_res;
                    zero_reg    <= (final_res == '0);
                    illegal_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed cases plus random ops against
// an arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [3:0]   alu_ctrl;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_result;
    logic         zero_flag;
    logic         illegal_op;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .alu_ctrl(alu_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .zero_flag(zero_flag), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference behaviour straight from the operation table.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [4:0]  sh;
        p     = {32'd0, a} * {32'd0, b};
        sh    = b[4:0];
        e.ill = 1'b0;
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a + b;
            4'd3:  e.res = a << sh;
            4'd4:  e.res = a - b;
            4'd5:  e.res = a >> sh;
            4'd6:  e.res = p[31:0];
            4'd7:  e.res = a ^ b;
            4'd8:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  e.res = $signed(a) >>> sh;
            4'd10: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd11: e.res = p[63:32];
            4'd12: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: e.res = (b == 0) ? a : a % b;
            default: begin
                e.res = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    function automatic bit is_iter(input logic [3:0] op);
        return (op == 4'd6) || (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
    endfunction

    // Monitor: pops the oldest expectation at every completed output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output got=%h want=none", alu_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn result=%h zero=%0b illegal=%0b expected=%h", alu_result, zero_flag, illegal_op, e.res);
                check("result", alu_result, e.res);
                check("zero_flag", {31'd0, zero_flag}, {31'd0, e.zero});
                check("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Issue one op, check latency and in_ready during BUSY, optionally stall
    // the consumer for 'hold' cycles while offering a competing request.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   lat;
        bit   busy_bad;
        e = model(op, a, b);
        out_ready = (hold == 0);
        wait_ready();
        in1 = a; in2 = b; alu_ctrl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = $urandom; in2 = $urandom; alu_ctrl = 4'($urandom);
        sb.push_back(e);
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), is_iter(op) ? 32'(W + 1) : 32'd1);
        check("busy_in_ready", {31'd0, busy_bad}, 32'd0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; in1 = $urandom; in2 = $urandom; alu_ctrl = 4'b0010;
                @(posedge clk); #1;
                check("hold_result", alu_result, e.res);
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    // Accept an op that will be aborted; no expectation is queued.
    task automatic start_only(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        in1 = a; in2 = b; alu_ctrl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; alu_ctrl = '0;
        flush = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_zero", {31'd0, zero_flag}, 32'd0);
        check("rst_illegal", {31'd0, illegal_op}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(4'b0100, 32'd5, 32'd5, 0);
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b1010, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b1001, 32'h8000_0000, 32'd36, 0);
        run_op(4'b0101, 32'h8000_0000, 32'd36, 0);
        run_op(4'b0110, 32'h0000_FFFF, 32'h0000_FFFF, 0);
        run_op(4'b1011, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(4'b1100, 32'd100, 32'd7, 0);
        run_op(4'b1101, 32'd100, 32'd7, 0);
        run_op(4'b1100, 32'd100, 32'd0, 0);
        run_op(4'b1101, 32'd100, 32'd0, 0);
        run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(4'b1110, 32'h0000_0001, 32'h0000_0001, 0);
        run_op(4'b0111, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 5);
        run_op(4'b0010, 32'd10, 32'd20, 0);

        // Flush in IDLE with a request present accepts nothing.
        flush = 1'b1; in_valid = 1'b1; alu_ctrl = 4'b0010; in1 = 32'd1; in2 = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("idle_flush_ready", {31'd0, in_ready}, 32'd1);
        expect_quiet("idle_flush_quiet", 3);

        // Flush on the 10th BUSY cycle of a divide.
        start_only(4'b1100, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        expect_quiet("flush_quiet", 40);
        run_op(4'b0010, 32'd2, 32'd3, 0);

        // Asynchronous reset in the middle of a divide.
        start_only(4'b1100, 32'd5000, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", alu_result, 32'd0);
        check("arst_zero", {31'd0, zero_flag}, 32'd0);
        check("arst_illegal", {31'd0, illegal_op}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_quiet("arst_quiet", 40);
        run_op(4'b0010, 32'd2, 32'd3, 0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(op, a, b, $urandom_range(0, 2));
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
